// File: rtl/cpu_pkg.sv
// Shared pipeline defaults and the address-width helper used across the CPU datapath.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write port and busy-set port.
interface regfile_mp_if
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RD_PORTS = 2
);
  localparam int AW = clog2(DEPTH);

  logic [RD_PORTS-1:0]        rd_en_i;
  logic [RD_PORTS*AW-1:0]     rd_addr_i;
  logic [RD_PORTS*DATA_W-1:0] rd_data_o;
  logic [RD_PORTS-1:0]        rd_busy_o;
  logic                       wr_en_i;
  logic [AW-1:0]              wr_addr_i;
  logic [DATA_W-1:0]          wr_data_i;
  logic                       busy_set_i;
  logic [AW-1:0]              busy_addr_i;

  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, busy_set_i, busy_addr_i,
    input  rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, busy_set_i, busy_addr_i,
    output rd_data_o, rd_busy_o
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: write/busy forwarding against the same-edge update, then output registers.
module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_busy_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              busy_set_i,
  input  logic [AW-1:0]     busy_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              rd_busy_reg, rd_busy_next;
  logic              wr_hit, set_hit;

  // Write/busy enables arrive already gated for the hardwired-zero register.
  assign wr_hit  = wr_en_i    && (wr_addr_i   == rd_addr_i);
  assign set_hit = busy_set_i && (busy_addr_i == rd_addr_i);

  always_comb begin
    rd_data_next = rd_data_reg;
    rd_busy_next = rd_busy_reg;
    if (rd_en_i) begin
      rd_data_next = wr_hit ? wr_data_i : mem_data_i;
      // Post-edge busy view: a new producer outranks the write that retires the old one.
      if (set_hit)
        rd_busy_next = 1'b1;
      else if (wr_hit)
        rd_busy_next = 1'b0;
      else
        rd_busy_next = mem_busy_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_reg <= '0;
      rd_busy_reg <= 1'b0;
    end else begin
      rd_data_reg <= rd_data_next;
      rd_busy_reg <= rd_busy_next;
    end
  end

  assign rd_data_o = rd_data_reg;
  assign rd_busy_o = rd_busy_reg;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard; storage and busy vector live here.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_mp_if.slave  bus
);
  localparam int AW = clog2(DEPTH);

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("regfile_mp: DEPTH must be a power of two and at least 2");
    end
    if (RD_PORTS < 1 || RD_PORTS > 4) begin : g_bad_ports
      $error("regfile_mp: RD_PORTS must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic              wr_go;
  logic              bset_go;

  // Register 0 swallows writes and busy sets so it always reads as an idle zero.
  assign wr_go   = bus.wr_en_i    && !((ZERO_REG != 0) && (bus.wr_addr_i   == '0));
  assign bset_go = bus.busy_set_i && !((ZERO_REG != 0) && (bus.busy_addr_i == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else if (wr_go) begin
      mem_reg[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  // The set is issued after the clear so a same-address set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_reg <= '0;
    end else begin
      if (wr_go)
        busy_reg[bus.wr_addr_i] <= 1'b0;
      if (bset_go)
        busy_reg[bus.busy_addr_i] <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_port
      logic [AW-1:0]     port_addr;
      logic [DATA_W-1:0] port_data;
      logic              port_busy;

      assign port_addr = bus.rd_addr_i[gi*AW +: AW];

      regfile_rd_port #(
        .DATA_W (DATA_W),
        .AW     (AW)
      ) u_rd_port (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_en_i     (bus.rd_en_i[gi]),
        .rd_addr_i   (port_addr),
        .mem_data_i  (mem_reg[port_addr]),
        .mem_busy_i  (busy_reg[port_addr]),
        .wr_en_i     (wr_go),
        .wr_addr_i   (bus.wr_addr_i),
        .wr_data_i   (bus.wr_data_i),
        .busy_set_i  (bset_go),
        .busy_addr_i (bus.busy_addr_i),
        .rd_data_o   (port_data),
        .rd_busy_o   (port_busy)
      );

      assign bus.rd_data_o[gi*DATA_W +: DATA_W] = port_data;
      assign bus.rd_busy_o[gi]                  = port_busy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table plus hand-written reset sequences, scoreboard-compared.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NP    = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .RD_PORTS(NP)) bus ();

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .RD_PORTS(NP), .ZERO_REG(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string             name;
    int                port;
    logic [DW-1:0]     data;
    logic              busy;
  } exp_t;

  typedef struct {
    string             name;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              bset;
    logic [AW-1:0]     baddr;
    logic [1:0]        rd_en;
    logic [AW-1:0]     a0;
    logic [AW-1:0]     a1;
    logic [DW-1:0]     e0;
    logic              b0;
    logic [DW-1:0]     e1;
    logic              b1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;
  int   txn    = 0;

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic drive(input logic wr_en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic bset, input logic [AW-1:0] ba,
                       input logic [1:0] rd_en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.wr_en_i     = wr_en;
    bus.wr_addr_i   = wa;
    bus.wr_data_i   = wd;
    bus.busy_set_i  = bset;
    bus.busy_addr_i = ba;
    bus.rd_en_i     = rd_en;
    bus.rd_addr_i   = {a1, a0};
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 2'b00, '0, '0);
  endtask

  task automatic expect_port(input string name, input int port, input logic [DW-1:0] d, input logic b);
    exp_t e;
    e.name = name;
    e.port = port;
    e.data = d;
    e.busy = b;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the current outputs.
  task automatic compare_now(input string tag);
    exp_t e;
    $display("txn %0d %s: p0=%h/%0b p1=%h/%0b", txn, tag,
             bus.rd_data_o[DW-1:0], bus.rd_busy_o[0], bus.rd_data_o[2*DW-1:DW], bus.rd_busy_o[1]);
    txn++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.name, "_data"}, bus.rd_data_o[e.port*DW +: DW], e.data);
      check_val({e.name, "_busy"}, {{(DW-1){1'b0}}, bus.rd_busy_o[e.port]}, {{(DW-1){1'b0}}, e.busy});
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    compare_now(tag);
  endtask

  task automatic add(input string n, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic bs, input logic [AW-1:0] ba, input logic [1:0] re,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] e0, input logic b0, input logic [DW-1:0] e1, input logic b1);
    vec_t v;
    v.name = n; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.bset = bs; v.baddr = ba;
    v.rd_en = re; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.b0 = b0; v.e1 = e1; v.b1 = b1;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name           we wa  wd            bs ba  re     a0  a1  e0            b0 e1            b1
    add("wr_r5",        1, 5,  32'hDEADBEEF, 0, 0,  2'b11, 1,  2,  32'h0,        0, 32'h0,        0);
    add("rd_r5",        0, 0,  32'h0,        0, 0,  2'b11, 5,  4,  32'hDEADBEEF, 0, 32'h0,        0);
    add("fwd_r7",       1, 7,  32'h12345678, 0, 0,  2'b11, 7,  7,  32'h12345678, 0, 32'h12345678, 0);
    add("wr_r0",        1, 0,  32'hFFFFFFFF, 0, 0,  2'b11, 0,  0,  32'h0,        0, 32'h0,        0);
    add("rd_r0",        0, 0,  32'h0,        0, 0,  2'b11, 0,  7,  32'h0,        0, 32'h12345678, 0);
    add("bset_r0",      0, 0,  32'h0,        1, 0,  2'b11, 0,  0,  32'h0,        0, 32'h0,        0);
    add("rd_r0_busy",   0, 0,  32'h0,        0, 0,  2'b11, 0,  5,  32'h0,        0, 32'hDEADBEEF, 0);
    add("bset_r9",      0, 0,  32'h0,        1, 9,  2'b11, 9,  9,  32'h0,        1, 32'h0,        1);
    add("rd_r9",        0, 0,  32'h0,        0, 0,  2'b11, 9,  5,  32'h0,        1, 32'hDEADBEEF, 0);
    add("wr_bset_r9",   1, 9,  32'hAAAA5555, 1, 9,  2'b11, 9,  9,  32'hAAAA5555, 1, 32'hAAAA5555, 1);
    add("rd_r9_busy",   0, 0,  32'h0,        0, 0,  2'b11, 9,  9,  32'hAAAA5555, 1, 32'hAAAA5555, 1);
    add("wr_r9_clr",    1, 9,  32'h00C0FFEE, 0, 0,  2'b11, 9,  7,  32'h00C0FFEE, 0, 32'h12345678, 0);
    add("hold_p0",      0, 0,  32'h0,        0, 0,  2'b10, 7,  5,  32'h00C0FFEE, 0, 32'hDEADBEEF, 0);
    add("hold_both",    1, 5,  32'h01010101, 0, 0,  2'b00, 5,  7,  32'h00C0FFEE, 0, 32'hDEADBEEF, 0);
    add("rd_r5_new",    0, 0,  32'h0,        0, 0,  2'b11, 5,  12, 32'h01010101, 0, 32'h0,        0);
    add("wr_bset_r12",  1, 12, 32'h00000011, 1, 12, 2'b11, 12, 13, 32'h00000011, 1, 32'h0,        0);
    add("wr13_bset14",  1, 13, 32'h00000022, 1, 14, 2'b11, 13, 14, 32'h00000022, 0, 32'h0,        1);
    add("wr14_bset15",  1, 14, 32'h00000066, 1, 15, 2'b11, 14, 15, 32'h00000066, 0, 32'h0,        1);
    add("wr_r3",        1, 3,  32'h33333333, 0, 0,  2'b11, 3,  12, 32'h33333333, 0, 32'h00000011, 1);

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_port("reset_p0", 0, '0, 1'b0);
    expect_port("reset_p1", 1, '0, 1'b0);
    compare_now("reset");
    @(negedge clk);
    rst = 1'b0;

    // Every address on both ports reads zero and idle after reset.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
      expect_port($sformatf("clr_p0_r%0d", a), 0, '0, 1'b0);
      expect_port($sformatf("clr_p1_r%0d", DEPTH - 1 - a), 1, '0, 1'b0);
      step("clear_scan");
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].bset, vecs[i].baddr,
            vecs[i].rd_en, vecs[i].a0, vecs[i].a1);
      expect_port({vecs[i].name, "_p0"}, 0, vecs[i].e0, vecs[i].b0);
      expect_port({vecs[i].name, "_p1"}, 1, vecs[i].e1, vecs[i].b1);
      step(vecs[i].name);
    end

    // Asynchronous reset mid-cycle while a write to r3 is pending.
    drive(1'b1, 5'd3, 32'h44444444, 1'b1, 5'd3, 2'b11, 5'd3, 5'd3);
    #2;
    rst = 1'b1;
    #1;
    expect_port("async_rst_p0", 0, '0, 1'b0);
    expect_port("async_rst_p1", 1, '0, 1'b0);
    compare_now("async_reset");
    // Inputs stay active across an edge held in reset; they must be ignored.
    @(posedge clk);
    #1;
    expect_port("rst_edge_p0", 0, '0, 1'b0);
    expect_port("rst_edge_p1", 1, '0, 1'b0);
    compare_now("reset_edge");
    @(negedge clk);
    rst = 1'b0;
    idle();

    drive(1'b0, '0, '0, 1'b0, '0, 2'b11, 5'd3, 5'd12);
    expect_port("post_rst_r3", 0, '0, 1'b0);
    expect_port("post_rst_r12", 1, '0, 1'b0);
    step("post_reset_read");

    drive(1'b1, 5'd3, 32'h00000055, 1'b0, '0, 2'b00, '0, '0);
    expect_port("resume_hold_p0", 0, '0, 1'b0);
    expect_port("resume_hold_p1", 1, '0, 1'b0);
    step("resume_write");

    drive(1'b0, '0, '0, 1'b0, '0, 2'b11, 5'd3, 5'd5);
    expect_port("resume_r3", 0, 32'h00000055, 1'b0);
    expect_port("resume_r5", 1, '0, 1'b0);
    step("resume_read");
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
